// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the sequential BCD to excess-3 converter.
// Optional digit range checking is enabled with BCD_XS3_ERRCHK_EN.
package bcd_xs3_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] XS3_OFFSET = 4'd3;
    localparam logic [DIGIT_W-1:0] BCD_MAX    = 4'd9;
    localparam logic [DIGIT_W-1:0] XS3_BAD    = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_xs3_digit.sv
// Single combinational BCD digit to excess-3 converter, shared by the controller.
// With BCD_XS3_ERRCHK_EN defined, digits above 9 map to 4'hF and raise invalid_o.
module bcd_xs3_digit
    import bcd_xs3_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd_i,
    output logic [DIGIT_W-1:0] xs3_o,
    output logic               invalid_o
);

    // Digit conversion and range flag
    always_comb begin
        xs3_o     = bcd_i + XS3_OFFSET;
        invalid_o = 1'b0;
`ifdef BCD_XS3_ERRCHK_EN
        if (bcd_i > BCD_MAX) begin
            xs3_o     = XS3_BAD;
            invalid_o = 1'b1;
        end else begin
            xs3_o     = bcd_i + XS3_OFFSET;
            invalid_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// Converts a packed NDIG-digit BCD word to excess-3, one digit per clock, LSD first.
// Digit range checking (err output) is enabled with BCD_XS3_ERRCHK_EN.
module bcd_xs3_seq_ctrl
    import bcd_xs3_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIGIT_W*NDIG-1:0] bcd_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIGIT_W*NDIG-1:0] xs3_out,
    output logic                    err,
    output logic                    busy
);

    localparam int WORD_W = DIGIT_W * NDIG;
    localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] CONV = ST_CONV;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [WORD_W-1:0]  src_q,   src_d;
    logic [WORD_W-1:0]  res_q,   res_d;
    logic               err_q,   err_d;

    logic [DIGIT_W-1:0] digit_bcd_s;
    logic [DIGIT_W-1:0] digit_xs3_s;
    logic               digit_bad_s;

    assign digit_bcd_s = src_q[idx_q*DIGIT_W +: DIGIT_W];

    bcd_xs3_digit u_digit (
        .bcd_i     (digit_bcd_s),
        .xs3_o     (digit_xs3_s),
        .invalid_o (digit_bad_s)
    );

    // Next-state, index and datapath register updates
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        src_d   = src_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d   = bcd_in;
                    res_d   = '0;
                    err_d   = 1'b0;
                    idx_d   = IDX_ZERO;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                res_d[idx_q*DIGIT_W +: DIGIT_W] = digit_xs3_s;
                err_d = err_q | digit_bad_s;
                // idx parks on the last digit; it is re-zeroed on the next accept
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = CONV;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = IDX_ZERO;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= IDX_ZERO;
            src_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CONV) || (state_q == DONE);
    assign xs3_out   = res_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Scoreboard bench for bcd_xs3_seq_ctrl (NDIG=4 main instance, NDIG=1 side instance).
module tb_bcd_xs3_seq_ctrl;

    typedef struct {
        logic [15:0] x;
        logic        e;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] bcd_in = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] xs3_out;
    logic        err;
    logic        busy;

    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [3:0]  bcd_in1 = 4'h0;
    logic        out_valid1;
    logic [3:0]  xs3_out1;
    logic        err1;
    logic        busy1;

    int   nvec = 0;
    int   nbad = 0;
    int   cyc  = 0;
    bit   prev_ov = 1'b0;
    exp_t q[$];

    bcd_xs3_seq_ctrl #(.NDIG(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .bcd_in(bcd_in), .out_valid(out_valid), .out_ready(out_ready),
        .xs3_out(xs3_out), .err(err), .busy(busy)
    );

    bcd_xs3_seq_ctrl #(.NDIG(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .bcd_in(bcd_in1), .out_valid(out_valid1), .out_ready(1'b1),
        .xs3_out(xs3_out1), .err(err1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare the presented result against the scoreboard head
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    nvec++;
                    nbad++;
                    $display("FAIL unexpected_output: got %0h with empty scoreboard", xs3_out);
                end else begin
                    check("xs3_out", {16'h0, xs3_out}, {16'h0, q[0].x});
                    check("err", {31'h0, err}, {31'h0, q[0].e});
                    check("done_in_ready", {31'h0, in_ready}, 32'h0);
                    if (!prev_ov) check("latency", cyc - q[0].acc, 32'd4);
                end
            end
            prev_ov = out_valid;
        end
    end

    // Retire the scoreboard head on the output handshake edge
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready && q.size() > 0) void'(q.pop_front());
    end

    task automatic send(input logic [15:0] w, input logic [15:0] x, input logic e,
                        input bit push, output int acc);
        int guard = 0;
        @(negedge clk); #1;
        in_valid = 1'b1;
        bcd_in   = w;
        while (!in_ready && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            nvec++;
            nbad++;
            $display("FAIL accept_timeout: word %0h not accepted", w);
        end
        @(posedge clk); #1;
        acc      = cyc;
        in_valid = 1'b0;
        bcd_in   = 16'hFFFF;
        if (push) q.push_back('{x: x, e: e, acc: acc});
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        nvec++;
        if (q.size() != 0) begin
            nbad++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  {31'h0, in_ready},  32'h1);
        check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, "_xs3_out"},   {16'h0, xs3_out},   32'h0);
        check({tag, "_err"},       {31'h0, err},       32'h0);
        check({tag, "_busy"},      {31'h0, busy},      32'h0);
    endtask

    initial begin
        int a0, a1, guard;
        logic [15:0] exp_bad;
        logic        exp_bad_err;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk); #1;
        rst = 1'b0;

        // basic conversion and latency
        send(16'h1234, 16'h4567, 1'b0, 1'b1, a0);
        drain();

        // back-to-back words at minimum period
        send(16'h9999, 16'hCCCC, 1'b0, 1'b1, a0);
        send(16'h0000, 16'h3333, 1'b0, 1'b1, a1);
        check("b2b_period", a1 - a0, 32'd6);
        drain();

        // back-pressure held in DONE
        out_ready = 1'b0;
        send(16'h4321, 16'h7654, 1'b0, 1'b1, a0);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        check("bp_out_valid", {31'h0, out_valid}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            in_valid = 1'b1;
            bcd_in   = 16'h0999;
            check("bp_in_ready", {31'h0, in_ready}, 32'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", {30'h0, in_ready, out_valid}, 32'h2);
        drain();

        // out-of-range digit
`ifdef BCD_XS3_ERRCHK_EN
        exp_bad     = 16'h45F7;
        exp_bad_err = 1'b1;
`else
        exp_bad     = 16'h45D7;
        exp_bad_err = 1'b0;
`endif
        send(16'h12A4, exp_bad, exp_bad_err, 1'b1, a0);
        drain();

        // valid word after an error word clears err
        send(16'h8076, 16'hB3A9, 1'b0, 1'b1, a0);
        drain();

        // asynchronous reset mid-conversion
        send(16'h5678, 16'h0000, 1'b0, 1'b0, a0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk); #1;
        rst = 1'b0;
        send(16'h0001, 16'h3334, 1'b0, 1'b1, a0);
        drain();

        // single-digit instance
        @(negedge clk); #1;
        in_valid1 = 1'b1;
        bcd_in1   = 4'h7;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        bcd_in1   = 4'h0;
        check("n1_busy_after_accept", {31'h0, busy1}, 32'h1);
        check("n1_not_valid_yet", {31'h0, out_valid1}, 32'h0);
        @(posedge clk); #1;
        check("n1_out_valid", {31'h0, out_valid1}, 32'h1);
        check("n1_xs3_out", {28'h0, xs3_out1}, 32'hA);
        @(posedge clk); #1;
        check("n1_back_idle", {31'h0, in_ready1}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
